// File: rtl/vram_console_if.sv
// Byte-stream input and VRAM write port of the text console.
// The slave modport is the console itself; the master modport is the byte
// producer, which also observes the VRAM write strobes.
interface vram_console_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] v_ada;
    logic       v_cea;
    logic [7:0] v_din;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output v_ada,
        output v_cea,
        output v_din
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  v_ada,
        input  v_cea,
        input  v_din
    );
endinterface

// File: rtl/vram_console.sv
// Text-console writer feeding the VRAM write port.
// After reset the whole COLS x ROWS screen is filled with FILL_CHAR, then
// bytes arriving on the valid/ready stream are written at a hardware cursor
// with CR/LF handling, line wrap and erase of every newly entered row.
// Optional feature: define VRAM_CONSOLE_BS_EN to treat 0x08 as backspace.
module vram_console #(
    parameter int          COLS      = 60,
    parameter int          ROWS      = 17,
    parameter logic [7:0]  FILL_CHAR = 8'h20
) (
    input  logic                clk,
    input  logic                rst,
    vram_console_if.slave       bus,
    output logic                boot_done,
    output logic [5:0]          cur_col,
    output logic [4:0]          cur_row
);

    localparam logic [1:0] S_CLEAR  = 2'd0;
    localparam logic [1:0] S_IDLE   = 2'd1;
    localparam logic [1:0] S_WRITE  = 2'd2;
    localparam logic [1:0] S_CLRROW = 2'd3;

    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;
`ifdef VRAM_CONSOLE_BS_EN
    localparam logic [7:0] CH_BS = 8'h08;
`endif

    localparam logic [5:0] LAST_COL    = 6'(COLS - 1);
    localparam logic [4:0] LAST_ROW    = 5'(ROWS - 1);
    localparam logic [9:0] COLS_W      = 10'(COLS);
    localparam logic [9:0] SCREEN_LAST = 10'(COLS * ROWS - 1);

    logic [1:0] state;
    logic [9:0] clr_addr;   // full-screen clear address
    logic [5:0] clr_cnt;    // cell index within the row being erased
    logic [9:0] row_base;   // address of column 0 of the cursor row

    logic [9:0] cell_addr;
    logic       last_row;
    logic [4:0] next_row;
    logic [9:0] next_base;
`ifdef VRAM_CONSOLE_BS_EN
    logic [9:0] prev_addr;
`endif

    // Cursor address and the row/base the cursor moves to on a row advance.
    always_comb begin
        cell_addr = row_base + {4'd0, cur_col};
        last_row  = (cur_row == LAST_ROW);
        next_row  = last_row ? 5'd0  : cur_row + 5'd1;
        next_base = last_row ? 10'd0 : row_base + COLS_W;
`ifdef VRAM_CONSOLE_BS_EN
        prev_addr = cell_addr - 10'd1;
`endif
    end

    // Controller: screen clear, byte acceptance, glyph write and row erase.
    // Every output is a register; in_ready and v_cea are never both high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_CLEAR;
            clr_addr     <= '0;
            clr_cnt      <= '0;
            row_base     <= '0;
            cur_col      <= '0;
            cur_row      <= '0;
            boot_done    <= 1'b0;
            bus.in_ready <= 1'b0;
            bus.v_cea    <= 1'b0;
            bus.v_ada    <= '0;
            bus.v_din    <= '0;
        end else begin
            case (state)
                S_CLEAR: begin
                    bus.v_cea <= 1'b1;
                    bus.v_ada <= clr_addr;
                    bus.v_din <= FILL_CHAR;
                    clr_addr  <= clr_addr + 10'd1;
                    if (clr_addr == SCREEN_LAST) begin
                        state <= S_IDLE;
                    end
                end

                S_WRITE: begin
                    // The glyph write was presented last cycle; reopen input.
                    bus.v_cea    <= 1'b0;
                    bus.in_ready <= 1'b1;
                    state        <= S_IDLE;
                end

                S_CLRROW: begin
                    bus.v_cea <= 1'b1;
                    bus.v_ada <= row_base + {4'd0, clr_cnt};
                    bus.v_din <= FILL_CHAR;
                    clr_cnt   <= clr_cnt + 6'd1;
                    if (clr_cnt == LAST_COL) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    boot_done <= 1'b1;
                    if (!bus.in_ready) begin
                        // Tail cycle after a clear: drop the strobe, open input.
                        bus.v_cea    <= 1'b0;
                        bus.in_ready <= 1'b1;
                    end else if (bus.in_valid) begin
                        if (bus.in_data == CH_CR) begin
                            cur_col   <= '0;
                            bus.v_cea <= 1'b0;
                        end else if (bus.in_data == CH_LF) begin
                            // First erase write goes out together with acceptance.
                            cur_col      <= '0;
                            cur_row      <= next_row;
                            row_base     <= next_base;
                            bus.v_cea    <= 1'b1;
                            bus.v_ada    <= next_base;
                            bus.v_din    <= FILL_CHAR;
                            clr_cnt      <= 6'd1;
                            bus.in_ready <= 1'b0;
                            state        <= S_CLRROW;
`ifdef VRAM_CONSOLE_BS_EN
                        end else if (bus.in_data == CH_BS) begin
                            // Backspace never leaves the current row.
                            if (cur_col == 6'd0) begin
                                bus.v_cea <= 1'b0;
                            end else begin
                                cur_col      <= cur_col - 6'd1;
                                bus.v_cea    <= 1'b1;
                                bus.v_ada    <= prev_addr;
                                bus.v_din    <= FILL_CHAR;
                                bus.in_ready <= 1'b0;
                                state        <= S_WRITE;
                            end
`endif
                        end else begin
                            bus.v_cea    <= 1'b1;
                            bus.v_ada    <= cell_addr;
                            bus.v_din    <= bus.in_data;
                            bus.in_ready <= 1'b0;
                            if (cur_col == LAST_COL) begin
                                // Wrap: erase of the new row starts next cycle.
                                cur_col  <= '0;
                                cur_row  <= next_row;
                                row_base <= next_base;
                                clr_cnt  <= '0;
                                state    <= S_CLRROW;
                            end else begin
                                cur_col <= cur_col + 6'd1;
                                state   <= S_WRITE;
                            end
                        end
                    end else begin
                        bus.v_cea <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vram_console.sv
// Self-checking bench for vram_console: a table of bytes with the expected
// cursor and ready latency, a cursor model that queues the expected VRAM
// writes, and a monitor that pops and compares every observed write.
module tb_vram_console;

    localparam int COLS = 60;
    localparam int ROWS = 17;

    logic       clk;
    logic       rst;
    logic       boot_done;
    logic [5:0] cur_col;
    logic [4:0] cur_row;

    vram_console_if bus();

    vram_console dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .boot_done (boot_done),
        .cur_col   (cur_col),
        .cur_row   (cur_row)
    );

    typedef struct packed {
        logic [9:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        logic [7:0] b;
        int         col;
        int         row;
        int         lat;
    } vec_t;

    wr_t  exp_q[$];
    vec_t vecs[$];
    wr_t  got_e;
    int   checks = 0;
    int   errors = 0;
    int   m_col  = 0;
    int   m_row  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every VRAM write must match the head of the expected queue.
    always @(negedge clk) begin
        if (bus.v_cea) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL vram_write: got addr=%0d data=%h, required no write",
                         bus.v_ada, bus.v_din);
            end else begin
                got_e = exp_q.pop_front();
                if (got_e.addr !== bus.v_ada || got_e.data !== bus.v_din) begin
                    errors++;
                    $display("FAIL vram_write: got addr=%0d data=%h, required addr=%0d data=%h",
                             bus.v_ada, bus.v_din, got_e.addr, got_e.data);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic add_vec(input logic [7:0] b, input int col, input int row, input int lat);
        vec_t v;
        v.b = b; v.col = col; v.row = row; v.lat = lat;
        vecs.push_back(v);
    endtask

    task automatic push_wr(input int row, input int col, input logic [7:0] d);
        wr_t w;
        w.addr = 10'(row * COLS + col);
        w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic model_adv_row();
        m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
        for (int c = 0; c < COLS; c++) push_wr(m_row, c, 8'h20);
    endtask

    // Cursor model: queues the writes one accepted byte must produce.
    task automatic model_byte(input logic [7:0] b);
        if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h0A) begin
            m_col = 0;
            model_adv_row();
`ifdef VRAM_CONSOLE_BS_EN
        end else if (b == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                push_wr(m_row, m_col, 8'h20);
            end
`endif
        end else begin
            push_wr(m_row, m_col, b);
            m_col++;
            if (m_col == COLS) begin
                m_col = 0;
                model_adv_row();
            end
        end
    endtask

    // Releases reset (called just after a posedge) and checks the full clear.
    task automatic boot_seq();
        int wr;
        wr = 0;
        for (int a = 0; a < COLS * ROWS; a++) begin
            wr_t w;
            w.addr = 10'(a);
            w.data = 8'h20;
            exp_q.push_back(w);
        end
        #2 rst = 1'b0;
        for (int i = 1; i <= 1021; i++) begin
            @(posedge clk); #1;
            if (i <= 1020 && bus.v_cea) wr++;
            if (i == 1020) chk("boot_pre_ready", {30'd0, boot_done, bus.in_ready}, 32'd0);
            if (i == 1021) chk("boot_done_ready", {29'd0, boot_done, bus.in_ready, bus.v_cea}, 32'b110);
        end
        chk("boot_write_count", wr, 1020);
        m_col = 0;
        m_row = 0;
    endtask

    // Sends one table byte (called at a negedge) and checks cursor and latency.
    task automatic send_vec(input vec_t v, input int idx);
        int n;
        n = 0;
        bus.in_data  = v.b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL vec%0d_ready_timeout: got in_ready=0, required 1", idx);
            bus.in_valid = 1'b0;
            return;
        end
        model_byte(v.b);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk($sformatf("vec%0d_cursor", idx), {16'd0, 2'd0, cur_row, 3'd0, cur_col},
            {16'd0, 2'd0, 5'(v.row), 3'd0, 6'(v.col)});
        n = 0;
        while (!bus.in_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("vec%0d_latency", idx), n, v.lat);
        @(negedge clk);
    endtask

    initial begin
        // Vector table: byte, cursor after acceptance, cycles until ready.
        for (int i = 0; i < 16; i++) add_vec(8'h0A, 0, i + 1, COLS);
        for (int i = 0; i < 59; i++) add_vec(8'h78, i + 1, 16, 1);
        add_vec(8'h78, 0, 0, COLS + 1);
        for (int i = 0; i < 3; i++) add_vec(8'h0A, 0, i + 1, COLS);
        add_vec(8'h68, 1, 3, 1);
        add_vec(8'h65, 2, 3, 1);
        add_vec(8'h6C, 3, 3, 1);
        add_vec(8'h6C, 4, 3, 1);
        add_vec(8'h6F, 5, 3, 1);
        add_vec(8'h0D, 0, 3, 0);
        add_vec(8'h0A, 0, 4, COLS);
        for (int i = 0; i < 13; i++) add_vec(8'h0A, 0, (5 + i) % ROWS, COLS);
        add_vec(8'h51, 1, 0, 1);
`ifdef VRAM_CONSOLE_BS_EN
        add_vec(8'h08, 0, 0, 1);
        add_vec(8'h00, 1, 0, 1);
`else
        add_vec(8'h08, 2, 0, 1);
        add_vec(8'h00, 3, 0, 1);
`endif

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {bus.v_ada, bus.v_cea, bus.v_din, bus.in_ready, boot_done, cur_col, cur_row}, 32'd0);

        boot_seq();

        // 'A','B' with in_valid held high: writes two cycles apart.
        @(negedge clk);
        model_byte(8'h41);
        model_byte(8'h42);
        bus.in_data  = 8'h41;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        chk("ab_first_write", {23'd0, bus.v_cea, bus.v_din}, {23'd0, 1'b1, 8'h41});
        bus.in_data = 8'h42;
        @(posedge clk); #1;
        chk("ab_idle_gap", {30'd0, bus.v_cea, bus.in_ready}, 32'b01);
        @(posedge clk); #1;
        chk("ab_second_write", {22'd0, bus.v_cea, bus.in_ready, bus.v_din}, {22'd0, 1'b1, 1'b0, 8'h42});
        bus.in_valid = 1'b0;
        chk("ab_cursor", {21'd0, cur_row, cur_col}, {21'd0, 5'd0, 6'd2});
        @(negedge clk);

        foreach (vecs[i]) send_vec(vecs[i], i);

        // Reset in the middle of a row erase aborts it and restarts the clear.
        model_byte(8'h0A);
        bus.in_data  = 8'h0A;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_clrrow", {bus.v_ada, bus.v_cea, bus.v_din, bus.in_ready, boot_done, cur_col, cur_row}, 32'd0);
        chk("clrrow_writes_before_rst", exp_q.size(), COLS - 21);
        exp_q.delete();
        @(posedge clk); #1;
        boot_seq();
        chk("cursor_after_reboot", {21'd0, cur_row, cur_col}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
